// File: rtl/core_lsu_pkg.sv
// Shared encodings for the load/store split unit: access sizes and controller states.
package core_lsu_pkg;

  localparam logic [1:0] SizeByte   = 2'd0;
  localparam logic [1:0] SizeHalf   = 2'd1;
  localparam logic [1:0] SizeWord   = 2'd2;
  localparam logic [1:0] SizeDouble = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StCap,
    StIss1,
    StDone
  } lsu_state_e;

endpackage

// File: rtl/core_lsu_align.sv
// Byte-lane steering for one access: per-beat strobes and write data, plus load
// extraction and extension from one or two bus words.
module core_lsu_align import core_lsu_pkg::*; #(
  parameter int unsigned XLEN = 64,
  localparam int unsigned BYTES = XLEN / 8,
  localparam int unsigned OFFW = $clog2(BYTES)
) (
  input  logic [OFFW-1:0]  off,
  input  logic [1:0]       size,
  input  logic             sext,
  input  logic             split,
  input  logic [XLEN-1:0]  wdata,
  input  logic [XLEN-1:0]  rdata_lo,
  input  logic [XLEN-1:0]  rdata_hi,
  output logic [BYTES-1:0] strb0,
  output logic [BYTES-1:0] strb1,
  output logic [XLEN-1:0]  wdata0,
  output logic [XLEN-1:0]  wdata1,
  output logic [XLEN-1:0]  rdata
);

  localparam int unsigned IDXW = $clog2(XLEN);

  logic [BYTES-1:0]   size_mask;
  logic [2*BYTES-1:0] strb_wide;
  logic [2*XLEN-1:0]  wdata_wide;
  logic [2*XLEN-1:0]  rdata_wide;
  logic [XLEN-1:0]    rdata_sh;
  logic [XLEN-1:0]    bit_mask;
  logic [IDXW-1:0]    sign_idx;
  logic               sign;

  always_comb begin
    case (size)
      SizeByte: size_mask = BYTES'(8'h01);
      SizeHalf: size_mask = BYTES'(8'h03);
      SizeWord: size_mask = BYTES'(8'h0F);
      default:  size_mask = BYTES'(8'hFF);
    endcase
  end

  always_comb begin
    bit_mask = '0;
    for (int i = 0; i < BYTES; i++) begin
      bit_mask[8*i +: 8] = {8{size_mask[i]}};
    end
  end

  // The upper half of each double-width shift is what spills into the second beat.
  assign strb_wide  = {{BYTES{1'b0}}, size_mask} << off;
  assign wdata_wide = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
  assign strb0      = strb_wide[BYTES-1:0];
  assign strb1      = strb_wide[2*BYTES-1:BYTES];
  assign wdata0     = wdata_wide[XLEN-1:0];
  assign wdata1     = wdata_wide[2*XLEN-1:XLEN];

  assign rdata_wide = split ? {rdata_hi, rdata_lo} : {{XLEN{1'b0}}, rdata_hi};
  assign rdata_sh   = XLEN'(rdata_wide >> {off, 3'b000});
  assign sign_idx   = IDXW'((32'd8 << size) - 32'd1);
  assign sign       = sext & rdata_sh[sign_idx];
  assign rdata      = (rdata_sh & bit_mask) | ({XLEN{sign}} & ~bit_mask);

endmodule

// File: rtl/core_lsu_split.sv
// Load/store unit front end: issues one or two aligned bus beats per access and
// merges split load data; misaligned accesses optionally trap instead.
module core_lsu_split import core_lsu_pkg::*; #(
  parameter int unsigned XLEN = 64,
  parameter bit MISALIGN_EN = 1'b1,
  localparam int unsigned BYTES = XLEN / 8
) (
  input  logic             g_clk,
  input  logic             g_resetn,
  input  logic             valid,
  input  logic [XLEN-1:0]  addr,
  input  logic [XLEN-1:0]  wdata,
  input  logic             load,
  input  logic             store,
  input  logic [1:0]       size,
  input  logic             sext,
  output logic             ready,
  output logic             trap_bus,
  output logic             trap_addr,
  output logic [XLEN-1:0]  rdata,
  output logic             dmem_req,
  output logic [XLEN-1:0]  dmem_addr,
  output logic             dmem_wen,
  output logic [BYTES-1:0] dmem_strb,
  output logic [XLEN-1:0]  dmem_wdata,
  input  logic             dmem_gnt,
  input  logic             dmem_err,
  input  logic [XLEN-1:0]  dmem_rdata
);

  localparam int unsigned OFFW = $clog2(BYTES);
  localparam int unsigned SPW  = OFFW + 2;

  lsu_state_e       state_q, state_d;
  logic [XLEN-1:0]  buf_q;
  logic             err_q;
  logic             taddr_q;

  logic [OFFW-1:0]  off;
  logic [SPW-1:0]   nbytes;
  logic [SPW-1:0]   span;
  logic             misalign;
  logic             split;
  logic             trap_mis;
  logic [XLEN-1:0]  addr_base;
  logic [BYTES-1:0] strb0, strb1;
  logic [XLEN-1:0]  wdata0, wdata1;
  logic             unused_load;

  assign off       = addr[OFFW-1:0];
  assign nbytes    = SPW'(1) << size;
  assign span      = SPW'(off) + nbytes;
  assign misalign  = |(SPW'(off) & (nbytes - SPW'(1)));
  assign split     = span > SPW'(BYTES);
  assign trap_mis  = misalign & ~MISALIGN_EN;
  assign addr_base = {addr[XLEN-1:OFFW], {OFFW{1'b0}}};
  // Direction comes from store alone; load is carried for the requester's benefit.
  assign unused_load = load;

  core_lsu_align #(
    .XLEN (XLEN)
  ) u_align (
    .off      (off),
    .size     (size),
    .sext     (sext),
    .split    (split),
    .wdata    (wdata),
    .rdata_lo (buf_q),
    .rdata_hi (dmem_rdata),
    .strb0    (strb0),
    .strb1    (strb1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .rdata    (rdata)
  );

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (valid) begin
          if (trap_mis)      state_d = StDone;
          else if (dmem_gnt) state_d = split ? StCap : StDone;
        end
      end
      StCap:   state_d = dmem_err ? StDone : StIss1;
      StIss1:  if (dmem_gnt) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready      = 1'b0;
    trap_bus   = 1'b0;
    trap_addr  = 1'b0;
    dmem_req   = 1'b0;
    dmem_addr  = addr_base;
    dmem_strb  = '0;
    dmem_wdata = wdata0;
    dmem_wen   = store;
    if (g_resetn) begin
      unique case (state_q)
        StIdle: begin
          if (valid && !trap_mis) begin
            dmem_req  = 1'b1;
            dmem_strb = strb0;
          end
        end
        StIss1: begin
          dmem_req   = 1'b1;
          dmem_addr  = addr_base + XLEN'(BYTES);
          dmem_strb  = strb1;
          dmem_wdata = wdata1;
        end
        StDone: begin
          ready     = 1'b1;
          trap_bus  = err_q | dmem_err;
          trap_addr = taddr_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      buf_q   <= '0;
      err_q   <= 1'b0;
      taddr_q <= 1'b0;
    end else begin
      if (state_q == StCap) begin
        buf_q <= dmem_rdata;
        err_q <= dmem_err;
      end else if (state_q == StIdle) begin
        err_q <= 1'b0;
      end
      if (state_q == StIdle) taddr_q <= valid & trap_mis;
    end
  end

  // The requester must hold valid from acceptance until the ready pulse.
  valid_held_busy: assert property (@(posedge g_clk) disable iff (!g_resetn)
    (state_q != StIdle) |-> valid);
  valid_held_wait: assert property (@(posedge g_clk) disable iff (!g_resetn)
    ($past(g_resetn && state_q == StIdle && valid && !dmem_gnt && !trap_mis)
     && state_q == StIdle) |-> valid);

endmodule

// File: tb/tb_core_lsu_split.sv
// Randomised bench for core_lsu_split against a byte-level memory model and a
// randomly stalling bus responder, plus directed corner cases.
module tb_core_lsu_split;
  import core_lsu_pkg::*;

  logic clk = 1'b0;
  logic g_resetn = 1'b0;
  always #5 clk = ~clk;

  logic        valid, load, store, sext;
  logic [1:0]  size;
  logic [63:0] addr, wdata;
  logic        ready, trap_bus, trap_addr;
  logic [63:0] rdata;
  logic        dmem_req, dmem_wen, dmem_gnt, dmem_err;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_strb;

  logic        valid2, ready2, trap_bus2, trap_addr2, req2, wen2;
  logic [63:0] rdata2, addr2, wd2;
  logic [7:0]  strb2;
  logic        gnt2 = 1'b0, err2 = 1'b0;
  logic [63:0] rd2 = 64'h0;

  core_lsu_split #(.XLEN(64), .MISALIGN_EN(1'b1)) u_dut (
    .g_clk(clk), .g_resetn(g_resetn), .valid(valid), .addr(addr), .wdata(wdata),
    .load(load), .store(store), .size(size), .sext(sext), .ready(ready),
    .trap_bus(trap_bus), .trap_addr(trap_addr), .rdata(rdata), .dmem_req(dmem_req),
    .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_err(dmem_err),
    .dmem_rdata(dmem_rdata)
  );

  core_lsu_split #(.XLEN(64), .MISALIGN_EN(1'b0)) u_dut_na (
    .g_clk(clk), .g_resetn(g_resetn), .valid(valid2), .addr(addr), .wdata(wdata),
    .load(load), .store(store), .size(size), .sext(sext), .ready(ready2),
    .trap_bus(trap_bus2), .trap_addr(trap_addr2), .rdata(rdata2), .dmem_req(req2),
    .dmem_addr(addr2), .dmem_wen(wen2), .dmem_strb(strb2), .dmem_wdata(wd2),
    .dmem_gnt(gnt2), .dmem_err(err2), .dmem_rdata(rd2)
  );

  int n_total = 0, n_bad = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bus side: memory image seen by the DUT, and the reference image.
  logic [7:0]  mem_bus [256];
  logic [7:0]  mem_ref [256];
  int          gnt_pct = 100;
  int          gnt_limit = 1 << 30;
  bit          err_next = 1'b0;
  bit          pend = 1'b0, pend_err = 1'b0;
  logic [63:0] pend_addr;
  logic [63:0] q_addr[$], q_wd[$];
  logic [7:0]  q_strb[$];
  logic        q_wen[$];
  int          q_cyc[$];
  logic        p_req = 1'b0, p_wen;
  logic [63:0] p_addr, p_wd;
  logic [7:0]  p_strb;

  function automatic logic [63:0] bus_word(input logic [63:0] a);
    logic [63:0] w;
    for (int j = 0; j < 8; j++) w[8*j +: 8] = mem_bus[8'(a + 64'(j))];
    return w;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (pend) begin
        dmem_rdata = bus_word(pend_addr);
        dmem_err   = pend_err;
      end else begin
        dmem_rdata = {$urandom, $urandom};
        dmem_err   = 1'b0;
      end
      pend = 1'b0;
      if (g_resetn && p_req) begin
        check_val("req_hold", 64'(dmem_req), 64'h1);
        check_val("addr_hold", dmem_addr, p_addr);
        check_val("strb_hold", 64'(dmem_strb), 64'(p_strb));
        check_val("wdata_hold", dmem_wdata, p_wd);
        check_val("wen_hold", 64'(dmem_wen), 64'(p_wen));
      end
      if (g_resetn && dmem_req && gnt_limit > 0 && $urandom_range(0, 99) < gnt_pct) begin
        dmem_gnt = 1'b1;
        gnt_limit--;
        q_addr.push_back(dmem_addr);
        q_strb.push_back(dmem_strb);
        q_wd.push_back(dmem_wdata);
        q_wen.push_back(dmem_wen);
        q_cyc.push_back(cyc_cnt);
        if (dmem_wen)
          for (int j = 0; j < 8; j++)
            if (dmem_strb[j]) mem_bus[8'(dmem_addr + 64'(j))] = dmem_wdata[8*j +: 8];
        pend = 1'b1;
        pend_addr = dmem_addr;
        pend_err = err_next;
        err_next = 1'b0;
      end else begin
        dmem_gnt = 1'b0;
      end
      p_req  = g_resetn && dmem_req && !dmem_gnt;
      p_addr = dmem_addr;
      p_strb = dmem_strb;
      p_wd   = dmem_wdata;
      p_wen  = dmem_wen;
    end
  end

  // Reference model: byte-addressed memory, expected beats derived byte by byte.
  int          e_n;
  logic [63:0] e_addr [2];
  logic [7:0]  e_strb [2];
  logic [63:0] e_wd [2];

  task automatic model_beats(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] wd);
    logic [63:0] base, b;
    int k, lane;
    base = a & ~64'h7;
    e_n = 1;
    for (int j = 0; j < 2; j++) begin
      e_addr[j] = base + 64'(8 * j);
      e_strb[j] = 8'h0;
      e_wd[j]   = 64'h0;
    end
    for (int i = 0; i < (1 << sz); i++) begin
      b = a + 64'(i);
      k = int'((b - base) >> 3);
      lane = int'(b[2:0]);
      if (k == 1) e_n = 2;
      e_strb[k][lane] = 1'b1;
      e_wd[k][8*lane +: 8] = wd[8*i +: 8];
    end
  endtask

  function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [1:0] sz,
                                           input logic sx);
    logic [63:0] v = 64'h0;
    int nb = 1 << sz;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = mem_ref[8'(a + 64'(i))];
    if (sx && v[8*nb-1]) for (int i = 8 * nb; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] lane_mask(input logic [7:0] s);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{s[i]}};
    return m;
  endfunction

  task automatic poke(input logic [63:0] a, input logic [7:0] d);
    mem_bus[a[7:0]] = d;
    mem_ref[a[7:0]] = d;
  endtask

  logic [63:0] o_rdata;
  logic        o_tbus, o_taddr;
  int          o_scyc, o_rcyc;

  task automatic do_op(input logic st, input logic [1:0] sz, input logic [63:0] a,
                       input logic [63:0] wd, input logic sx);
    bit got = 1'b0;
    q_addr.delete(); q_strb.delete(); q_wd.delete(); q_wen.delete(); q_cyc.delete();
    @(posedge clk); #1;
    valid = 1'b1; load = !st; store = st; size = sz; addr = a; wdata = wd; sext = sx;
    o_scyc = cyc_cnt;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk); #1;
      if (ready) begin
        got = 1'b1;
        o_rdata = rdata; o_tbus = trap_bus; o_taddr = trap_addr; o_rcyc = cyc_cnt;
        check_val("req_in_done", 64'(dmem_req), 64'h0);
      end
    end
    check_val("ready_seen", 64'(got), 64'h1);
    @(posedge clk); #1;
    valid = 1'b0; load = 1'b0; store = 1'b0;
    @(negedge clk); #1;
    check_val("ready_once", 64'(ready), 64'h0);
  endtask

  task automatic run_checked(input logic st, input logic [1:0] sz, input logic [63:0] a,
                             input logic [63:0] wd, input logic sx);
    logic [63:0] exp_rd;
    model_beats(a, sz, wd);
    exp_rd = ref_load(a, sz, sx);
    do_op(st, sz, a, wd, sx);
    check_val("beats", 64'(q_addr.size()), 64'(e_n));
    for (int k = 0; k < e_n && k < q_addr.size(); k++) begin
      check_val("beat_addr", q_addr[k], e_addr[k]);
      check_val("beat_strb", 64'(q_strb[k]), 64'(e_strb[k]));
      check_val("beat_wdata", q_wd[k] & lane_mask(e_strb[k]), e_wd[k]);
      check_val("beat_wen", 64'(q_wen[k]), 64'(st));
    end
    if (q_cyc.size() > 0) check_val("latency", 64'(o_rcyc), 64'(q_cyc[q_cyc.size()-1] + 1));
    if (q_cyc.size() == 2) check_val("split_gap", 64'(q_cyc[1] - q_cyc[0] >= 2), 64'h1);
    check_val("trap_bus", 64'(o_tbus), 64'h0);
    check_val("trap_addr", 64'(o_taddr), 64'h0);
    if (st) begin
      for (int i = 0; i < (1 << sz); i++) mem_ref[8'(a + 64'(i))] = wd[8*i +: 8];
    end else begin
      check_val("load_data", o_rdata, exp_rd);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] sz;
    valid = 1'b0; load = 1'b0; store = 1'b0; sext = 1'b0; size = 2'd0;
    addr = 64'h0; wdata = 64'h0; valid2 = 1'b0;
    dmem_gnt = 1'b0; dmem_err = 1'b0; dmem_rdata = 64'h0;
    for (int i = 0; i < 256; i++) begin
      mem_bus[i] = 8'($urandom);
      mem_ref[i] = mem_bus[i];
    end
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_val("rst_ready", 64'(ready), 64'h0);
    check_val("rst_req", 64'(dmem_req), 64'h0);
    check_val("rst_strb", 64'(dmem_strb), 64'h0);
    @(posedge clk); #1;
    g_resetn = 1'b1;
    @(negedge clk); #1;
    check_val("idle_ready", 64'(ready), 64'h0);
    check_val("idle_req", 64'(dmem_req), 64'h0);
    check_val("idle_tbus", 64'(trap_bus), 64'h0);
    check_val("idle_taddr", 64'(trap_addr), 64'h0);

    // LW sext straddling nothing, immediate grant.
    gnt_pct = 100;
    for (int i = 0; i < 8; i++) poke(64'h1000 + 64'(i), (i == 7) ? 8'h80 : 8'h00);
    run_checked(1'b0, SizeWord, 64'h1004, 64'h0, 1'b1);
    check_val("lw_addr", q_addr[0], 64'h1000);
    check_val("lw_strb", 64'(q_strb[0]), 64'hF0);
    check_val("lw_cycle", 64'(o_rcyc - o_scyc), 64'h1);
    check_val("lw_rdata", o_rdata, 64'hFFFFFFFF_80000000);

    // Split doubleword store.
    run_checked(1'b1, SizeDouble, 64'h1006, 64'h1122334455667788, 1'b0);
    if (q_addr.size() == 2) begin
      check_val("sd_a0", q_addr[0], 64'h1000);
      check_val("sd_s0", 64'(q_strb[0]), 64'hC0);
      check_val("sd_w0", q_wd[0], 64'h77880000_00000000);
      check_val("sd_a1", q_addr[1], 64'h1008);
      check_val("sd_s1", 64'(q_strb[1]), 64'h3F);
      check_val("sd_w1", q_wd[1], 64'h00001122_33445566);
    end

    // Split halfword load, zero- and sign-extended.
    poke(64'h1007, 8'hAB);
    poke(64'h1008, 8'hCD);
    run_checked(1'b0, SizeHalf, 64'h1007, 64'h0, 1'b0);
    check_val("lh_zext", o_rdata, 64'h0000_0000_0000_CDAB);
    gnt_pct = 40;
    run_checked(1'b0, SizeHalf, 64'h1007, 64'h0, 1'b1);
    check_val("lh_sext", o_rdata, 64'hFFFF_FFFF_FFFF_CDAB);

    // Misaligned word on the trapping instance.
    @(posedge clk); #1;
    addr = 64'h1002; size = SizeWord; load = 1'b1; sext = 1'b0; valid2 = 1'b1;
    @(negedge clk); #1;
    check_val("na_req0", 64'(req2), 64'h0);
    check_val("na_ready0", 64'(ready2), 64'h0);
    @(negedge clk); #1;
    check_val("na_req1", 64'(req2), 64'h0);
    check_val("na_ready1", 64'(ready2), 64'h1);
    check_val("na_trap", 64'(trap_addr2), 64'h1);
    check_val("na_tbus", 64'(trap_bus2), 64'h0);
    @(posedge clk); #1;
    valid2 = 1'b0; load = 1'b0;
    @(negedge clk); #1;
    check_val("na_ready2", 64'(ready2), 64'h0);

    // Bus error on the first beat of a split load: no second beat.
    gnt_pct = 100;
    err_next = 1'b1;
    do_op(1'b0, SizeWord, 64'h100E, 64'h0, 1'b0);
    check_val("err_beats", 64'(q_addr.size()), 64'h1);
    check_val("err_tbus", 64'(o_tbus), 64'h1);
    check_val("err_taddr", 64'(o_taddr), 64'h0);

    // Stall the second beat, then reset in the middle of it.
    gnt_limit = 1;
    q_addr.delete(); q_strb.delete(); q_wd.delete(); q_wen.delete(); q_cyc.delete();
    @(posedge clk); #1;
    valid = 1'b1; store = 1'b1; load = 1'b0; size = SizeDouble; addr = 64'h1016;
    wdata = 64'hA5A5_5A5A_0F0F_F0F0;
    for (int c = 0; c < 20 && q_addr.size() == 0; c++) @(negedge clk);
    repeat (5) @(negedge clk);
    #1;
    check_val("stall_req", 64'(dmem_req), 64'h1);
    check_val("stall_addr", dmem_addr, 64'h1018);
    @(posedge clk); #1;
    g_resetn = 1'b0;
    @(negedge clk); #1;
    check_val("mid_rst_req", 64'(dmem_req), 64'h0);
    check_val("mid_rst_ready", 64'(ready), 64'h0);
    @(posedge clk); #1;
    g_resetn = 1'b1; valid = 1'b0; store = 1'b0;
    gnt_limit = 1 << 30;
    @(negedge clk); #1;
    check_val("post_rst_req", 64'(dmem_req), 64'h0);
    check_val("post_rst_ready", 64'(ready), 64'h0);
    check_val("post_rst_strb", 64'(dmem_strb), 64'h0);
    for (int i = 0; i < 256; i++) mem_ref[i] = mem_bus[i];
    run_checked(1'b0, SizeDouble, 64'h1010, 64'h0, 1'b0);

    // Random mix of sizes, offsets, directions and grant stalls.
    for (int n = 0; n < 200; n++) begin
      gnt_pct = $urandom_range(30, 100);
      sz = 2'($urandom_range(0, 3));
      run_checked(1'($urandom_range(0, 1)), sz, 64'h1000 + 64'($urandom_range(0, 'h6F)),
                  {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/core_lsu_split.md
CORE_LSU_SPLIT -- requirements
Module: core_lsu_split

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, meaning data and bus width (32 or 64); BYTES = XLEN/8.
REQ-002 The block SHALL have parameter MISALIGN_EN, default 1, meaning 1 splits misaligned accesses into two bus beats and 0 raises trap_addr instead.
REQ-003 The block SHALL have port g_clk, input, 1 bit: clock.
REQ-004 The block SHALL have port g_resetn, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port valid, input, 1 bit: request valid, held stable until ready.
REQ-006 The block SHALL have port addr, input, XLEN bits: byte address.
REQ-007 The block SHALL have port wdata, input, XLEN bits: store data, LSB-aligned.
REQ-008 The block SHALL have ports load and store, input, 1 bit each: access type.
REQ-009 The block SHALL have port size, input, 2 bits: 0 byte, 1 half, 2 word, 3 double (3 illegal when XLEN=32).
REQ-010 The block SHALL have port sext, input, 1 bit: sign-extend load data.
REQ-011 The block SHALL have port ready, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have ports trap_bus and trap_addr, output, 1 bit each: bus-error and alignment trap, valid with ready.
REQ-013 The block SHALL have port rdata, output, XLEN bits: load result, valid with ready.
REQ-014 The block SHALL have ports dmem_req (out, 1), dmem_addr (out, XLEN), dmem_wen (out, 1), dmem_strb (out, BYTES), dmem_wdata (out, XLEN), dmem_gnt (in, 1), dmem_err (in, 1) and dmem_rdata (in, XLEN): the data bus.

Function
REQ-015 Bus protocol SHALL be: dmem_req held with stable addr, wen, strb and wdata until dmem_gnt; dmem_rdata and dmem_err valid the cycle after gnt.
REQ-016 dmem_addr SHALL always be BYTES-aligned; off = addr mod BYTES; nbytes = 1<<size.
REQ-017 An access SHALL be misaligned when off is not a multiple of nbytes, and split when off+nbytes > BYTES.
REQ-018 FSM states SHALL be IDLE, CAP, ISS1 and DONE.
REQ-019 In IDLE with valid, when the access is misaligned and MISALIGN_EN=0, the block SHALL assert no request, go to DONE, and assert ready and trap_addr next cycle.
REQ-020 In IDLE with valid and a legal access, the block SHALL drive beat0 (addr aligned down, strb bytes off..min(off+nbytes,BYTES)-1, wdata<<8*off); on gnt it SHALL go to CAP if split, else DONE.
REQ-021 In CAP (one cycle), the block SHALL latch dmem_rdata into a buffer and dmem_err into err_q; it SHALL go to DONE if dmem_err, else ISS1.
REQ-022 In ISS1, beat1 SHALL use addr+BYTES aligned, strb bytes 0..off+nbytes-BYTES-1, and wdata>>8*(BYTES-off); on gnt the block SHALL go to DONE.
REQ-023 In DONE, the block SHALL assert ready for one cycle, then go to IDLE; dmem_req SHALL be 0 in DONE.
REQ-024 Unsplit rdata SHALL be dmem_rdata>>8*off, masked to nbytes, and sign-extended if sext.
REQ-025 Split rdata SHALL be {dmem_rdata, buffer} shifted right by 8*off, masked to nbytes, and sign-extended if sext.
REQ-026 trap_bus SHALL equal ready && (err_q || dmem_err); after a beat0 error, beat1 SHALL NOT be issued.
REQ-027 dmem_wen SHALL equal store during any request.
REQ-028 Latency SHALL be: aligned, gnt at cycle N gives ready at N+1; split, gnt0 at N, CAP at N+1, beat1 request from N+2, gnt1 at M gives ready at M+1.
REQ-029 valid deasserting before ready SHALL be illegal and checked by an assertion.

Reset
REQ-030 While g_resetn=0, state SHALL be IDLE, and ready, trap_bus, trap_addr, dmem_req, dmem_strb, err_q and buffer SHALL be 0; this SHALL apply from any state, including ISS1 with a pending request.
REQ-031 rdata SHALL be don't-care while ready=0.

Structure
REQ-032 Package core_lsu_pkg SHALL hold the size encoding constants and the FSM state enum.
REQ-033 Sub-module core_lsu_align (combinational) SHALL generate per-beat strobes, write shifts and read extraction/extension; the FSM and buffers SHALL stay in core_lsu_split.

Verification
REQ-034 XLEN=64, LW sext addr 0x1004, rdata 0x80000000_00000000, gnt in cycle 1 -> dmem_addr 0x1000, strb 0xF0, ready in cycle 2, rdata 0xFFFFFFFF_80000000.
REQ-035 SD addr 0x1006, wdata 0x1122334455667788 -> beat0 0x1000 strb 0xC0 wdata 0x77880000_00000000; beat1 0x1008 strb 0x3F wdata 0x00001122_33445566; a single ready.
REQ-036 LH addr 0x1007, beat0 byte7=0xAB, beat1 byte0=0xCD -> sext=0 gives rdata 0xCDAB; sext=1 gives 0xFFFFFFFF_FFFFCDAB.
REQ-037 MISALIGN_EN=0, LW addr 0x1002 -> dmem_req never asserts; ready and trap_addr next cycle.
REQ-038 Split load with dmem_err on beat0 -> no beat1 request; ready with trap_bus=1.
REQ-039 gnt withheld for 3 cycles in ISS1 with request stable, then g_resetn=0 -> next cycle dmem_req=0, ready=0, IDLE.
